// File: rtl/pipe_stage_buf_pkg.sv
// Shared constants for the flow-controlled pipeline stage register.
// Word width and NOP encoding mirror the core-wide define header.
package pipe_stage_buf_pkg;

  localparam int WORD_WIDTH = 32;

  localparam logic [WORD_WIDTH-1:0] NOP_ENC = 32'h0000_0013;

endpackage

// File: rtl/pipe_skid_slot.sv
// One valid+data register with load, clear and flush-to-bubble.
// Priority: reset, flush, load, clear.
import pipe_stage_buf_pkg::*;

module pipe_skid_slot #(
  parameter int DATA_WIDTH = WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  load,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] zero_point,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      data  <= zero_point;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage with flush bubble and stall counter.
// PIPE_SKID_BUF_EN adds a skid entry and registers in_ready.
import pipe_stage_buf_pkg::*;

module pipe_stage_buf #(
  parameter int DATA_WIDTH      = WORD_WIDTH,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_flag,
  input  logic [DATA_WIDTH-1:0]      zero_point,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [STALL_CNT_WIDTH-1:0] stall_cnt
);

  localparam logic [STALL_CNT_WIDTH-1:0] CNT_ONE =
    {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                  head_v;
  logic [DATA_WIDTH-1:0] head_d;
  logic                  head_load;
  logic                  head_clear;
  logic [DATA_WIDTH-1:0] head_src;
  logic                  in_fire;
  logic                  out_fire;

  assign out_valid = head_v;
  assign out_data  = head_d;
  assign out_fire  = head_v & out_ready;

`ifdef PIPE_SKID_BUF_EN
  logic                  skid_v;
  logic [DATA_WIDTH-1:0] skid_d;
  logic                  head_free;
  logic                  skid_load;
  logic                  skid_clear;

  // Head can take a new entry if empty or draining this edge.
  assign head_free  = !head_v || out_ready;
  assign in_ready   = !skid_v;
  assign in_fire    = in_valid & in_ready;
  assign head_load  = head_free & (skid_v | in_fire);
  assign head_src   = skid_v ? skid_d : in_data;
  assign head_clear = out_fire;
  assign skid_load  = in_fire & !head_free;
  assign skid_clear = skid_v & head_free;

  pipe_skid_slot #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush_flag),
    .load      (skid_load),
    .clear     (skid_clear),
    .zero_point(zero_point),
    .load_data (in_data),
    .valid     (skid_v),
    .data      (skid_d)
  );
`else
  assign in_ready   = !head_v || out_ready;
  assign in_fire    = in_valid & in_ready;
  assign head_load  = in_fire;
  assign head_src   = in_data;
  assign head_clear = out_fire;
`endif

  pipe_skid_slot #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_head (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush_flag),
    .load      (head_load),
    .clear     (head_clear),
    .zero_point(zero_point),
    .load_data (head_src),
    .valid     (head_v),
    .data      (head_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule
